fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Parametrised successor to the RV32IF EX-stage forwarding unit. It resolves RAW hazards for NSRC source operands across the integer and FP register files. It forwards MEM/WB results, raises a load-use stall, and runs a scoreboard FSM for one outstanding long-latency FP op (fdiv/fsqrt). Sits between ID/EX pipeline registers and EX operand muxes; stall/bubble outputs drive the hazard control of IF/ID and ID/EX.

Parameters:
XLEN, 32, datapath width
NSRC, 3, source operands per instruction (3 covers fmadd rs3)
LAT_W, 5, width of long-op latency counter
PERF_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
id_rs  in  NSRC*5  ID-stage source register indices
id_rs_fp  in  NSRC  per source: 1 = FP file
id_rs_valid  in  NSRC  per source: operand used
id_is_long  in  1  ID instruction is a long-latency FP op
ex_rs  in  NSRC*5  EX-stage source indices
ex_rs_fp  in  NSRC  EX source file select
ex_rf_data  in  NSRC*XLEN  register-file read values for EX operands
ex_rd  in  5  EX destination
ex_rd_fp  in  1  EX destination is FP
ex_reg_write  in  1  EX writes a register
ex_is_load  in  1  EX instruction is a load (lw/flw)
ex_long_issue  in  1  EX issues a long op this cycle
ex_long_lat  in  LAT_W  cycles until long result is written (>=1)
mem_rd, mem_rd_fp, mem_reg_write, mem_is_load  in  5/1/1/1  MEM stage destination info
mem_result  in  XLEN  MEM-stage ALU result
wb_rd, wb_rd_fp, wb_reg_write  in  5/1/1  WB stage destination info
wb_result  in  XLEN  WB-stage writeback value
fwd_sel  out  NSRC*2  per source: 00 RF, 10 MEM, 01 WB
fwd_data  out  NSRC*XLEN  resolved operand values
stall_id  out  1  hold PC and IF/ID
bubble_ex  out  1  insert NOP into ID/EX
long_busy  out  1  long op outstanding
long_rd  out  5  destination of outstanding long op
long_rd_fp  out  1  file of outstanding long op
long_done  out  1  one-cycle pulse: long result writes this cycle
stall_cycles  out  PERF_W  saturating count of stalled cycles

Behaviour:
- Register match: same index AND same file bit. Integer x0 never matches (never forwarded, never stalls). FP f0 is a normal register.
- Forwarding, combinational, per source i, only when id/ex source is valid:
  - MEM match with mem_reg_write and !mem_is_load gives sel 10, data mem_result.
  - Otherwise WB match with wb_reg_write gives sel 01, data wb_result.
  - Otherwise sel 00, data ex_rf_data[i].
  - MEM has priority over WB on a double match.
- Load-use: ex_is_load & ex_reg_write & any valid ID source matching ex_rd/ex_rd_fp asserts stall_id=1 and bubble_ex=1 for exactly that cycle. The consumer then forwards from WB.
- Long-op FSM, states IDLE and BUSY:
  - IDLE: ex_long_issue loads cnt=ex_long_lat and latches long_rd/long_rd_fp, then moves to BUSY.
  - BUSY: cnt decrements each cycle. When cnt==1, long_done=1 (registered output, asserted in the cycle cnt reads 1) and the next state is IDLE.
  - ex_long_issue while BUSY is ignored and the state is unchanged; ID stalling makes it unreachable in a correct pipeline.
  - ex_long_lat==0 is treated as 1.
- Scoreboard stall: in BUSY, stall_id=bubble_ex=1 if id_is_long (structural), or if any valid ID source matches long_rd/long_rd_fp (RAW).
  - In the cycle long_done=1 the RAW stall still holds; it is released the following cycle, when the value is forwardable from WB.
- stall_id and bubble_ex are the OR of the load-use and scoreboard conditions.
- stall_cycles increments every cycle stall_id=1 and saturates at all-ones.
- Reset (async, rst_n=0, including mid long op):
  - Registered state: FSM IDLE, cnt=0, long_busy=0, long_done=0, long_rd=0, long_rd_fp=0, stall_cycles=0.
  - Combinational outputs then follow inputs: stall only from load-use; fwd_sel/fwd_data per the forwarding rules above.
- long_busy = (state==BUSY).

Test Plan:
- Integer ALU chain: MEM writes x5=0x11, WB writes x5=0x22, ex_rs[0]=x5 int -> fwd_sel[0]=10, fwd_data=0x11. Repeat with MEM idle -> 01, 0x22.
- x0 vs f0: MEM writes x0 int with 0xDEAD and ex_rs[1]=x0 -> sel 00, data from RF. MEM writes f0 FP and ex_rs[1]=f0 FP -> sel 10. Same index, other file -> sel 00.
- Load-use: EX flw f3, ID fadd reads f3 -> stall_id=bubble_ex=1 for 1 cycle. Next cycle the consumer in EX gets sel 01, wb_result.
- Long op: issue fdiv f7 with lat=4 -> long_busy for 4 cycles, long_done pulses on the 4th, ID reading f7 stalls 4 cycles, stall_cycles +=4. An ID fadd not reading f7 is not stalled.
- Structural: second fsqrt in ID while BUSY -> stall until the cycle after long_done, then issue accepted.
- Reset mid-op: rst_n low at cnt=2 -> immediately IDLE, long_busy=0, long_done never pulses, stall_cycles=0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding, load-use detection and single-entry long-op scoreboard.
// Forwarding/stall are combinational; long-op state, long_done and stall counter are registered.
module fwd_hazard_unit #(
  parameter int XLEN   = 32,
  parameter int NSRC   = 3,
  parameter int LAT_W  = 5,
  parameter int PERF_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC*5-1:0]    id_rs,
  input  logic [NSRC-1:0]      id_rs_fp,
  input  logic [NSRC-1:0]      id_rs_valid,
  input  logic                 id_is_long,
  input  logic [NSRC*5-1:0]    ex_rs,
  input  logic [NSRC-1:0]      ex_rs_fp,
  input  logic [NSRC*XLEN-1:0] ex_rf_data,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_rd_fp,
  input  logic                 ex_reg_write,
  input  logic                 ex_is_load,
  input  logic                 ex_long_issue,
  input  logic [LAT_W-1:0]     ex_long_lat,
  input  logic [4:0]           mem_rd,
  input  logic                 mem_rd_fp,
  input  logic                 mem_reg_write,
  input  logic                 mem_is_load,
  input  logic [XLEN-1:0]      mem_result,
  input  logic [4:0]           wb_rd,
  input  logic                 wb_rd_fp,
  input  logic                 wb_reg_write,
  input  logic [XLEN-1:0]      wb_result,
  output logic [NSRC*2-1:0]    fwd_sel,
  output logic [NSRC*XLEN-1:0] fwd_data,
  output logic                 stall_id,
  output logic                 bubble_ex,
  output logic                 long_busy,
  output logic [4:0]           long_rd,
  output logic                 long_rd_fp,
  output logic                 long_done,
  output logic [PERF_W-1:0]    stall_cycles
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        long_rd_q, long_rd_d;
  logic              long_rd_fp_q, long_rd_fp_d;
  logic              long_done_q, long_done_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_hit, long_hit, load_use, sb_stall;

  // x0 is hardwired zero, so it never aliases a producer; f0 is an ordinary register.
  function automatic logic reg_match(input logic [4:0] a, input logic a_fp,
                                     input logic [4:0] b, input logic b_fp);
    return (a == b) && (a_fp == b_fp) && !((a == 5'd0) && !a_fp);
  endfunction

  always_comb begin
    fwd_sel  = '0;
    fwd_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (mem_reg_write && !mem_is_load &&
          reg_match(ex_rs[i*5 +: 5], ex_rs_fp[i], mem_rd, mem_rd_fp)) begin
        fwd_sel[i*2 +: 2]     = 2'b10;
        fwd_data[i*XLEN +: XLEN] = mem_result;
      end else if (wb_reg_write &&
                   reg_match(ex_rs[i*5 +: 5], ex_rs_fp[i], wb_rd, wb_rd_fp)) begin
        fwd_sel[i*2 +: 2]     = 2'b01;
        fwd_data[i*XLEN +: XLEN] = wb_result;
      end else begin
        fwd_sel[i*2 +: 2]     = 2'b00;
        fwd_data[i*XLEN +: XLEN] = ex_rf_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    load_hit = 1'b0;
    long_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_rs_valid[i] && reg_match(id_rs[i*5 +: 5], id_rs_fp[i], ex_rd, ex_rd_fp))
        load_hit = 1'b1;
      if (id_rs_valid[i] && reg_match(id_rs[i*5 +: 5], id_rs_fp[i], long_rd_q, long_rd_fp_q))
        long_hit = 1'b1;
    end
    load_use = ex_is_load && ex_reg_write && load_hit;
    // Held through the long_done cycle; the result is only forwardable from WB afterwards.
    sb_stall = (state_q == S_BUSY) && (id_is_long || long_hit);
  end

  assign stall_id  = load_use || sb_stall;
  assign bubble_ex = stall_id;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    long_rd_d    = long_rd_q;
    long_rd_fp_d = long_rd_fp_q;
    case (state_q)
      S_IDLE: begin
        if (ex_long_issue) begin
          state_d      = S_BUSY;
          cnt_d        = (ex_long_lat == '0) ? LAT_W'(1) : ex_long_lat;
          long_rd_d    = ex_rd;
          long_rd_fp_d = ex_rd_fp;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q <= LAT_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    long_done_d = (state_d == S_BUSY) && (cnt_d == LAT_W'(1));
    stall_cnt_d = stall_cnt_q;
    if (stall_id && (stall_cnt_q != {PERF_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      long_rd_q    <= '0;
      long_rd_fp_q <= 1'b0;
      long_done_q  <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      long_rd_q    <= long_rd_d;
      long_rd_fp_q <= long_rd_fp_d;
      long_done_q  <= long_done_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign long_busy    = (state_q == S_BUSY);
  assign long_rd      = long_rd_q;
  assign long_rd_fp   = long_rd_fp_q;
  assign long_done    = long_done_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with a queue of expected values checked per step.
module tb_fwd_hazard_unit;
  localparam int XLEN = 32;
  localparam int NSRC = 3;
  localparam int LATW = 5;
  localparam int PW   = 4;
  localparam int SMAX = (1 << PW) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NSRC*5-1:0]    id_rs;
  logic [NSRC-1:0]      id_rs_fp, id_rs_valid;
  logic                 id_is_long;
  logic [NSRC*5-1:0]    ex_rs;
  logic [NSRC-1:0]      ex_rs_fp;
  logic [NSRC*XLEN-1:0] ex_rf_data;
  logic [4:0]           ex_rd;
  logic                 ex_rd_fp, ex_reg_write, ex_is_load, ex_long_issue;
  logic [LATW-1:0]      ex_long_lat;
  logic [4:0]           mem_rd;
  logic                 mem_rd_fp, mem_reg_write, mem_is_load;
  logic [XLEN-1:0]      mem_result;
  logic [4:0]           wb_rd;
  logic                 wb_rd_fp, wb_reg_write;
  logic [XLEN-1:0]      wb_result;
  logic [NSRC*2-1:0]    fwd_sel;
  logic [NSRC*XLEN-1:0] fwd_data;
  logic                 stall_id, bubble_ex, long_busy, long_rd_fp, long_done;
  logic [4:0]           long_rd;
  logic [PW-1:0]        stall_cycles;

  fwd_hazard_unit #(.XLEN(XLEN), .NSRC(NSRC), .LAT_W(LATW), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rs_fp(id_rs_fp), .id_rs_valid(id_rs_valid), .id_is_long(id_is_long),
    .ex_rs(ex_rs), .ex_rs_fp(ex_rs_fp), .ex_rf_data(ex_rf_data),
    .ex_rd(ex_rd), .ex_rd_fp(ex_rd_fp), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_long_issue(ex_long_issue), .ex_long_lat(ex_long_lat),
    .mem_rd(mem_rd), .mem_rd_fp(mem_rd_fp), .mem_reg_write(mem_reg_write),
    .mem_is_load(mem_is_load), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_rd_fp(wb_rd_fp), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .long_busy(long_busy), .long_rd(long_rd), .long_rd_fp(long_rd_fp),
    .long_done(long_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   ms    = 0;

  task automatic pe(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%0h required=<no expectation queued>", tag, obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val && e.tag == tag) else begin
        bad++;
        $error("FAIL %s observed=%0h required=%0h (queued tag %s)", tag, obs, e.val, e.tag);
      end
    end
  endtask

  task automatic pe_std(input logic busy, input logic done, input logic st);
    pe("scnt", 64'(ms));
    pe("busy", 64'(busy));
    pe("done", 64'(done));
    pe("stall", 64'(st));
    pe("bubble", 64'(st));
    if (st && ms < SMAX) ms++;
  endtask

  task automatic chk_std();
    chk("scnt", 64'(stall_cycles));
    chk("busy", 64'(long_busy));
    chk("done", 64'(long_done));
    chk("stall", 64'(stall_id));
    chk("bubble", 64'(bubble_ex));
  endtask

  task automatic pe_src(input int i, input logic [1:0] sel, input logic [XLEN-1:0] dat);
    pe($sformatf("sel%0d", i), 64'(sel));
    pe($sformatf("dat%0d", i), 64'(dat));
  endtask

  task automatic chk_src(input int i);
    chk($sformatf("sel%0d", i), 64'(fwd_sel[i*2 +: 2]));
    chk($sformatf("dat%0d", i), 64'(fwd_data[i*XLEN +: XLEN]));
  endtask

  task automatic pe_lrd(input logic [4:0] rd, input logic fp);
    pe("long_rd", 64'(rd));
    pe("long_rd_fp", 64'(fp));
  endtask

  task automatic chk_lrd();
    chk("long_rd", 64'(long_rd));
    chk("long_rd_fp", 64'(long_rd_fp));
  endtask

  task automatic clr();
    id_rs = '0; id_rs_fp = '0; id_rs_valid = '0; id_is_long = 1'b0;
    ex_rs = '0; ex_rs_fp = '0; ex_rf_data = '0;
    ex_rd = '0; ex_rd_fp = 1'b0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
    ex_long_issue = 1'b0; ex_long_lat = '0;
    mem_rd = '0; mem_rd_fp = 1'b0; mem_reg_write = 1'b0; mem_is_load = 1'b0; mem_result = '0;
    wb_rd = '0; wb_rd_fp = 1'b0; wb_reg_write = 1'b0; wb_result = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic id_reads_f7();
    id_rs[4:0] = 5'd7; id_rs_fp[0] = 1'b1; id_rs_valid[0] = 1'b1;
  endtask

  task automatic ex_load_f3_id_reads_f3();
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd3; ex_rd_fp = 1'b1;
    id_rs[4:0] = 5'd3; id_rs_fp[0] = 1'b1; id_rs_valid[0] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    #2;
    pe_lrd(5'd0, 1'b0);
    pe("selall", 64'd0);
    pe_std(1'b0, 1'b0, 1'b0);
    #1;
    chk_lrd();
    chk("selall", 64'(fwd_sel));
    chk_std();
    @(negedge clk);
    rst_n = 1'b1;

    // Integer chain: MEM beats WB, then WB alone, then a MEM load defers to WB
    cyc(); clr();
    ex_rs[4:0] = 5'd5; ex_rf_data[31:0] = 32'hAA;
    mem_rd = 5'd5; mem_reg_write = 1'b1; mem_result = 32'h11;
    wb_rd = 5'd5; wb_reg_write = 1'b1; wb_result = 32'h22;
    pe_src(0, 2'b10, 32'h11); pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_src(0); chk_std();

    cyc(); mem_reg_write = 1'b0;
    pe_src(0, 2'b01, 32'h22); pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_src(0); chk_std();

    cyc(); mem_reg_write = 1'b1; mem_is_load = 1'b1;
    pe_src(0, 2'b01, 32'h22); pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_src(0); chk_std();

    // x0 never forwards; f0 does; same index in the other file does not
    cyc(); clr();
    ex_rs[9:5] = 5'd0; ex_rf_data[63:32] = 32'h33;
    mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'hDEAD;
    wb_rd = 5'd0; wb_reg_write = 1'b1; wb_result = 32'hBEEF;
    pe_src(1, 2'b00, 32'h33); pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_src(1); chk_std();

    cyc(); mem_rd_fp = 1'b1; ex_rs_fp[1] = 1'b1;
    pe_src(1, 2'b10, 32'hDEAD); pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_src(1); chk_std();

    cyc(); ex_rs[9:5] = 5'd4; ex_rs_fp[1] = 1'b0; mem_rd = 5'd4; mem_rd_fp = 1'b1;
    pe_src(1, 2'b00, 32'h33); pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_src(1); chk_std();

    // Load-use on f3, then the consumer picks it up from WB
    cyc(); clr(); ex_load_f3_id_reads_f3();
    pe_std(1'b0, 1'b0, 1'b1);
    #3; chk_std();

    cyc(); clr();
    ex_rs[4:0] = 5'd3; ex_rs_fp[0] = 1'b1; ex_rf_data[31:0] = 32'h55;
    wb_rd = 5'd3; wb_rd_fp = 1'b1; wb_reg_write = 1'b1; wb_result = 32'h77;
    pe_src(0, 2'b01, 32'h77); pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_src(0); chk_std();

    cyc(); clr(); ex_load_f3_id_reads_f3(); id_rs_valid[0] = 1'b0;
    pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_std();

    cyc(); clr(); ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0;
    id_rs[9:5] = 5'd0; id_rs_valid[1] = 1'b1;
    pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_std();

    cyc(); clr(); ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd3; ex_rd_fp = 1'b1;
    id_rs[14:10] = 5'd3; id_rs_valid[2] = 1'b1;
    pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_std();

    cyc(); id_rs_fp[2] = 1'b1;
    pe_std(1'b0, 1'b0, 1'b1);
    #3; chk_std();

    // fdiv f7, latency 4, with a dependent instruction waiting in ID
    cyc(); clr(); ex_long_issue = 1'b1; ex_long_lat = 5'd4;
    ex_rd = 5'd7; ex_rd_fp = 1'b1; ex_reg_write = 1'b1; id_reads_f7();
    pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_std();
    for (int k = 1; k <= 4; k++) begin
      cyc(); clr(); id_reads_f7();
      pe_lrd(5'd7, 1'b1); pe_std(1'b1, k == 4, 1'b1);
      #3; chk_lrd(); chk_std();
    end
    cyc(); clr(); id_reads_f7();
    pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_std();

    // fdiv f9 latency 3: independent op passes, second long op waits, stray issue ignored
    cyc(); clr(); ex_long_issue = 1'b1; ex_long_lat = 5'd3; ex_rd = 5'd9; ex_rd_fp = 1'b1;
    pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_std();

    cyc(); clr(); id_rs[4:0] = 5'd8; id_rs_fp[0] = 1'b1; id_rs_valid[0] = 1'b1;
    pe_lrd(5'd9, 1'b1); pe_std(1'b1, 1'b0, 1'b0);
    #3; chk_lrd(); chk_std();

    cyc(); clr(); id_is_long = 1'b1; ex_long_issue = 1'b1; ex_long_lat = 5'd5; ex_rd = 5'd1;
    pe_lrd(5'd9, 1'b1); pe_std(1'b1, 1'b0, 1'b1);
    #3; chk_lrd(); chk_std();

    cyc(); clr(); id_is_long = 1'b1;
    pe_lrd(5'd9, 1'b1); pe_std(1'b1, 1'b1, 1'b1);
    #3; chk_lrd(); chk_std();

    cyc(); clr(); id_is_long = 1'b1; ex_long_issue = 1'b1; ex_long_lat = 5'd0; ex_rd = 5'd10;
    pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_std();

    cyc(); clr();
    pe_lrd(5'd10, 1'b0); pe_std(1'b1, 1'b1, 1'b0);
    #3; chk_lrd(); chk_std();

    cyc(); clr();
    pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_std();

    // Reset lands while the counter reads 2
    cyc(); clr(); ex_long_issue = 1'b1; ex_long_lat = 5'd4; ex_rd = 5'd7; ex_rd_fp = 1'b1;
    pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_std();
    for (int k = 0; k < 2; k++) begin
      cyc(); clr(); id_reads_f7();
      pe_std(1'b1, 1'b0, 1'b1);
      #3; chk_std();
    end
    cyc(); clr(); id_reads_f7(); rst_n = 1'b0;
    ms = 0;
    pe_lrd(5'd0, 1'b0); pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_lrd(); chk_std();
    for (int k = 0; k < 3; k++) begin
      cyc(); clr(); id_reads_f7(); rst_n = 1'b1;
      pe_std(1'b0, 1'b0, 1'b0);
      #3; chk_std();
    end

    // Counter saturation under a held load-use stall
    for (int k = 0; k < 20; k++) begin
      cyc(); clr(); ex_load_f3_id_reads_f3();
      pe_std(1'b0, 1'b0, 1'b1);
      #3; chk_std();
    end
    cyc(); clr();
    pe_std(1'b0, 1'b0, 1'b0);
    #3; chk_std();

    if (sbq.size() != 0) begin
      bad++;
      $error("FAIL leftover observed=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
